// File: rtl/rv_pkg.sv
// Shared RV32 definitions used by the EX-stage M-extension unit.
// Contents:
//   XLEN / CNT_W       datapath width and iteration-counter width
//   F3_*               M-extension funct3 encodings
//   F7_MULDIV          funct7 value that selects the M extension on opcode OP
//   muldiv_state_e     2-bit state encoding of the mul/div sequencer
//   f3_is_div()        funct3 belongs to the divide/remainder group
package rv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } muldiv_state_e;

  function automatic logic f3_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Bundle between the ID/EX operand launch, the mul/div unit, and the
// hazard/write-back logic.
//   start     master->slave  valid M-ext op sitting in EX
//   funct3    master->slave  operation select
//   rs1_data  master->slave  operand A
//   rs2_data  master->slave  operand B
//   busy      slave->master  stall request (freeze PC, IF/ID, ID/EX)
//   done      slave->master  one-cycle result-valid pulse
//   result    slave->master  result, held until the next accepted op
//
// Handshake: an op is transferred on a rising edge where start=1 and the
// unit is idle; start is the valid, and the unit's readiness is implied by
// being idle. busy follows start combinationally during that cycle so the
// op stays in EX; start while an op is in flight (or in the done cycle) is
// ignored and operands are not re-sampled. done rises exactly once per
// accepted op, XLEN+2 cycles after acceptance, or on the next cycle for
// divide-by-zero and signed overflow.
interface ex_muldiv_unit_if;
  import rv_pkg::*;

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, rs1_data, rs2_data,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data,
    output busy, done, result
  );

endinterface

// File: rtl/muldiv_iter_core.sv
// Radix-2 iterative datapath shared by multiply and divide.
//   clk, rst     clock, asynchronous active-high reset
//   i_load       load operands (acc cleared)
//   i_step       perform one iteration
//   i_mode_div   1 = restoring divide, 0 = shift-add multiply
//   i_op_a       unsigned operand A (multiplicand / dividend)
//   i_op_b       unsigned operand B (multiplier / divisor)
//   o_hi         acc: product high half / remainder
//   o_lo         shift reg: product low half / quotient
// Multiply: {acc, sr} is shifted right each step; sr starts as the
// multiplier and its LSB gates the add of the multiplicand into acc.
// Divide: {acc, sr} is shifted left; sr starts as the dividend and the
// quotient bits are shifted in at its LSB.
module muldiv_iter_core #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_step,
  input  logic         i_mode_div,
  input  logic [W-1:0] i_op_a,
  input  logic [W-1:0] i_op_b,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo
);

  logic [W-1:0] r_acc;
  logic [W-1:0] r_sr;
  logic [W-1:0] r_m;

  logic [W:0]   w_add;
  logic [W:0]   w_rem_sh;
  logic         w_ge;
  logic [W-1:0] w_diff;

  always_comb begin
    w_add    = {1'b0, r_acc} + (r_sr[0] ? {1'b0, r_m} : '0);
    w_rem_sh = {r_acc, r_sr[W-1]};
    w_ge     = (w_rem_sh >= {1'b0, r_m});
    // When w_ge holds the true difference is below r_m, so W bits suffice.
    w_diff   = w_rem_sh[W-1:0] - r_m;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_sr  <= '0;
      r_m   <= '0;
    end else if (i_load) begin
      r_acc <= '0;
      r_sr  <= i_mode_div ? i_op_a : i_op_b;
      r_m   <= i_mode_div ? i_op_b : i_op_a;
    end else if (i_step) begin
      if (i_mode_div) begin
        r_acc <= w_ge ? w_diff : w_rem_sh[W-1:0];
        r_sr  <= {r_sr[W-2:0], w_ge};
      end else begin
        r_acc <= w_add[W:1];
        r_sr  <= {w_add[0], r_sr[W-1:1]};
      end
    end
  end

  assign o_hi = r_acc;
  assign o_lo = r_sr;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage RV32M execution unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   bus          ex_muldiv_unit_if.slave: start/funct3/rs1/rs2 in,
//                busy/done/result out
//   o_dbg_state  current sequencer state
// Operands are converted to magnitudes at accept, run through the
// iterative core for XLEN cycles, then sign-fixed in FIX. Divide-by-zero
// and signed overflow bypass the core and complete in DONE next cycle.
module ex_muldiv_unit
  import rv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  ex_muldiv_unit_if.slave  bus,
  output muldiv_state_e    o_dbg_state
);

  localparam logic [XLEN-1:0]  SMIN     = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);

  muldiv_state_e    r_state;
  muldiv_state_e    w_next;
  logic [2:0]       r_funct3;
  logic             r_neg_p;
  logic             r_neg_r;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_result;

  logic             w_busy;
  logic             w_done;
  logic             w_accept;
  logic             w_sign_a;
  logic             w_sign_b;
  logic [XLEN-1:0]  w_mag_a;
  logic [XLEN-1:0]  w_mag_b;
  logic             w_div_zero;
  logic             w_ovf;
  logic             w_special;
  logic [XLEN-1:0]  w_special_val;
  logic             w_load;
  logic             w_step;
  logic             w_mode_div;
  logic [XLEN-1:0]  w_hi;
  logic [XLEN-1:0]  w_lo;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]  w_fix_val;

  // Sign prep: only the signed operand positions of each op contribute a sign.
  always_comb begin
    w_sign_a = 1'b0;
    w_sign_b = 1'b0;
    case (bus.funct3)
      F3_MULH, F3_DIV, F3_REM: begin
        w_sign_a = bus.rs1_data[XLEN-1];
        w_sign_b = bus.rs2_data[XLEN-1];
      end
      F3_MULHSU: w_sign_a = bus.rs1_data[XLEN-1];
      default: ;
    endcase
    w_mag_a = w_sign_a ? -bus.rs1_data : bus.rs1_data;
    w_mag_b = w_sign_b ? -bus.rs2_data : bus.rs2_data;
  end

  // Special-case detection; funct3[1] separates REM* from DIV*.
  always_comb begin
    w_div_zero    = f3_is_div(bus.funct3) && (bus.rs2_data == '0);
    w_ovf         = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
                    (bus.rs1_data == SMIN) && (bus.rs2_data == '1);
    w_special     = w_div_zero | w_ovf;
    w_special_val = '0;
    if (w_div_zero)
      w_special_val = bus.funct3[1] ? bus.rs1_data : '1;
    else if (w_ovf)
      w_special_val = bus.funct3[1] ? '0 : SMIN;
  end

  // Sequencer next state and handshake outputs.
  always_comb begin
    w_next   = r_state;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      MD_IDLE: begin
        w_busy   = bus.start;
        w_accept = bus.start;
        if (bus.start) w_next = w_special ? MD_DONE : MD_CALC;
      end
      MD_CALC: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_LAST) w_next = MD_FIX;
      end
      MD_FIX: begin
        w_busy = 1'b1;
        w_next = MD_DONE;
      end
      MD_DONE: begin
        w_done = 1'b1;
        w_next = MD_IDLE;
      end
      default: w_next = MD_IDLE;
    endcase
  end

  // The core must see the new op's mode on the load cycle, before r_funct3 updates.
  always_comb begin
    w_load     = w_accept & ~w_special;
    w_step     = (r_state == MD_CALC);
    w_mode_div = w_load ? f3_is_div(bus.funct3) : f3_is_div(r_funct3);
  end

  muldiv_iter_core #(.W(XLEN)) u_core (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_mode_div (w_mode_div),
    .i_op_a     (w_mag_a),
    .i_op_b     (w_mag_b),
    .o_hi       (w_hi),
    .o_lo       (w_lo)
  );

  // Sign fix and field select.
  always_comb begin
    w_prod_s = r_neg_p ? -{w_hi, w_lo} : {w_hi, w_lo};
    case (r_funct3)
      F3_MUL:                       w_fix_val = w_prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_fix_val = w_prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              w_fix_val = r_neg_p ? -w_lo : w_lo;
      default:                      w_fix_val = r_neg_r ? -w_hi : w_hi;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= MD_IDLE;
      r_funct3 <= '0;
      r_neg_p  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_funct3 <= bus.funct3;
        r_neg_p  <= w_sign_a ^ w_sign_b;
        r_neg_r  <= w_sign_a;
        r_cnt    <= '0;
        if (w_special) r_result <= w_special_val;
      end
      if (r_state == MD_CALC) r_cnt <= r_cnt + 1'b1;
      if (r_state == MD_FIX)  r_result <= w_fix_val;
    end
  end

  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.result  = r_result;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
  import rv_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  muldiv_state_e dbg_state;

  ex_muldiv_unit_if bus_if ();

  ex_muldiv_unit dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          exp_busy_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          busy_cnt = 0;
  logic [31:0] last_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (architectural RV32M rules) ----------------
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, r;
    logic [63:0] p;
    logic [31:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (f3)
      3'd0: begin r = sa * sb; p = r; res = p[31:0]; end
      3'd1: begin r = sa * sb; p = r; res = p[63:32]; end
      3'd2: begin r = sa * longint'({32'h0, b}); p = r; res = p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; res = p[63:32]; end
      3'd4: begin
        if (b == 32'h0) res = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'h8000_0000;
        else begin r = sa / sb; p = r; res = p[31:0]; end
      end
      3'd5: res = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'h0) res = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'h0;
        else begin r = sa % sb; p = r; res = p[31:0]; end
      end
      default: res = (b == 32'h0) ? a : a % b;
    endcase
    return res;
  endfunction

  // Stall cycles per op: 1 for the bypass cases, XLEN+2 otherwise.
  function automatic int ref_busy(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 32'h0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit hold);
    int guard = 0;
    @(negedge clk);
    while (dbg_state != MD_IDLE && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      check("idle_timeout", 32'(dbg_state), 32'(MD_IDLE));
      return;
    end
    check("result_hold", bus_if.result, last_res);
    bus_if.start    = 1'b1;
    bus_if.funct3   = f3;
    bus_if.rs1_data = a;
    bus_if.rs2_data = b;
    last_res = ref_model(f3, a, b);
    exp_q.push_back(last_res);
    exp_busy_q.push_back(ref_busy(f3, a, b));
    @(posedge clk);
    #1;
    if (!hold) bus_if.start = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [31:0] e;
    int          eb;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        busy_cnt = 0;
      end else if (bus_if.done) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got result 0x%08h with no op pending at %0t", bus_if.result, $time);
        end else begin
          e  = exp_q.pop_front();
          eb = exp_busy_q.pop_front();
          check("result", bus_if.result, e);
          check("busy_cycles", 32'(busy_cnt), 32'(eb));
          check("busy_in_done", {31'h0, bus_if.busy}, 32'h0);
        end
        busy_cnt = 0;
      end else if (bus_if.busy) begin
        busy_cnt++;
      end
    end
  end

  // ---------------- directed table ----------------
  logic [2:0]  d_f3[12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                            3'd4, 3'd7, 3'd4, 3'd6};
  logic [31:0] d_a[12]  = '{32'h7, 32'h7, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                            32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h5, 32'h5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b[12]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h7, 32'h2, 32'h2,
                            32'h2, 32'h2, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    bus_if.start    = 1'b0;
    bus_if.funct3   = 3'd0;
    bus_if.rs1_data = '0;
    bus_if.rs2_data = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy",   {31'h0, bus_if.busy}, 32'h0);
    check("rst_done",   {31'h0, bus_if.done}, 32'h0);
    check("rst_result", bus_if.result, 32'h0);
    check("rst_state",  32'(dbg_state), 32'(MD_IDLE));
    #3 rst = 1'b0;

    // Idle with start low: nothing moves
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_busy",   {31'h0, bus_if.busy}, 32'h0);
      check("idle_done",   {31'h0, bus_if.done}, 32'h0);
      check("idle_result", bus_if.result, 32'h0);
    end

    // Directed multiply, divide and bypass cases
    for (int i = 0; i < 12; i++) issue(d_f3[i], d_a[i], d_b[i], 1'b0);

    // Start held high; operands change mid-CALC and must not be re-sampled
    begin
      logic [2:0]  f3n;
      logic [31:0] an, bn;
      issue(3'd0, 32'h7, 32'hFFFF_FFFD, 1'b1);
      repeat (10) @(negedge clk);
      f3n = 3'd5;
      an  = $urandom;
      bn  = 32'($urandom_range(1, 1000));
      bus_if.funct3   = f3n;
      bus_if.rs1_data = an;
      bus_if.rs2_data = bn;
      issue(f3n, an, bn, 1'b0);
    end

    // Randomized ops
    for (int i = 0; i < 40; i++) begin
      logic [2:0] f3r;
      f3r = 3'($urandom_range(0, 7));
      issue(f3r, pick_operand(), pick_operand(), 1'b0);
    end

    // Reset at CALC count 10: op aborted, no done, result cleared
    issue(3'd4, 32'd1000, 32'd3, 1'b0);
    repeat (11) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_busy",   {31'h0, bus_if.busy}, 32'h0);
    check("abort_done",   {31'h0, bus_if.done}, 32'h0);
    check("abort_result", bus_if.result, 32'h0);
    exp_q.delete();
    exp_busy_q.delete();
    last_res = '0;
    @(negedge clk);
    #3 rst = 1'b0;
    issue(3'd5, 32'd100, 32'd7, 1'b0);

    // Drain
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'h0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
